// File: rtl/awg_cmd_parser.sv
// ASCII command parser: letter + 1..MAX_DIGITS decimal digits + CR/LF -> AWG control registers.
// Commit 1 cycle after the terminator; no backpressure (one byte per rx_valid). Optional idle abort: AWG_CMD_TIMEOUT_EN.
module awg_cmd_parser #(
  parameter int WAVE_W         = 3,
  parameter int FREQ_W         = 12,
  parameter int AMP_W          = 3,
  parameter int PHASE_W        = 8,
  parameter int MAX_DIGITS     = 5,
  parameter int DEF_WAVE       = 0,
  parameter int DEF_FREQ       = 1,
  parameter int DEF_AMP        = 1,
  parameter int DEF_PHASE      = 0,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [WAVE_W-1:0]  wave_sel,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [AMP_W-1:0]   amp_sel,
  output logic [PHASE_W-1:0] phase_off,
  output logic               upd,
  output logic [1:0]         upd_field,
  output logic               cmd_err,
  output logic               busy
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [1:0] FLD_WAVE  = 2'd0;
  localparam logic [1:0] FLD_FREQ  = 2'd1;
  localparam logic [1:0] FLD_AMP   = 2'd2;
  localparam logic [1:0] FLD_PHASE = 2'd3;

  localparam int ACC_W01 = (WAVE_W > FREQ_W) ? WAVE_W : FREQ_W;
  localparam int ACC_W23 = (AMP_W > PHASE_W) ? AMP_W : PHASE_W;
  localparam int ACC_W   = (ACC_W01 > ACC_W23) ? ACC_W01 : ACC_W23;
  localparam int PW      = ACC_W + 4;

  localparam logic [3:0] CNT_MAX = 4'(MAX_DIGITS);

  logic [0:0]         state_q, state_d;
  logic [1:0]         field_q, field_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WAVE_W-1:0]  wave_q, wave_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               upd_q, upd_d;
  logic [1:0]         ufld_q, ufld_d;
  logic               err_q, err_d;

`ifdef AWG_CMD_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;
`endif

  logic             is_digit, is_term, is_letter;
  logic [1:0]       letter_fld;
  logic [ACC_W-1:0] lim_acc;
  logic [PW-1:0]    prod;

  always_comb begin
    is_digit   = (rx_data >= 8'd48) && (rx_data <= 8'd57);
    is_term    = (rx_data == 8'd13) || (rx_data == 8'd10);
    is_letter  = 1'b1;
    letter_fld = FLD_WAVE;
    case (rx_data)
      8'd119:  letter_fld = FLD_WAVE;
      8'd102:  letter_fld = FLD_FREQ;
      8'd97:   letter_fld = FLD_AMP;
      8'd112:  letter_fld = FLD_PHASE;
      default: is_letter  = 1'b0;
    endcase
  end

  // Saturation ceiling is the all-ones value of the field currently being collected.
  always_comb begin
    case (field_q)
      FLD_WAVE:  lim_acc = {ACC_W{1'b1}} >> (ACC_W - WAVE_W);
      FLD_FREQ:  lim_acc = {ACC_W{1'b1}} >> (ACC_W - FREQ_W);
      FLD_AMP:   lim_acc = {ACC_W{1'b1}} >> (ACC_W - AMP_W);
      default:   lim_acc = {ACC_W{1'b1}} >> (ACC_W - PHASE_W);
    endcase
  end

  assign prod = PW'(acc_q) * PW'(10) + PW'(rx_data[3:0]);

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wave_d  = wave_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    phase_d = phase_q;
    upd_d   = 1'b0;
    ufld_d  = ufld_q;
    err_d   = 1'b0;
`ifdef AWG_CMD_TIMEOUT_EN
    tmo_d   = '0;
`endif
    if (rx_valid) begin
      if (state_q == ST_IDLE) begin
        if (is_letter) begin
          state_d = ST_COLLECT;
          field_d = letter_fld;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (!is_term) begin
          err_d = 1'b1;
        end
      end else begin
        if (is_digit) begin
          if (cnt_q == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            acc_d = (prod > PW'(lim_acc)) ? lim_acc : prod[ACC_W-1:0];
            cnt_d = cnt_q + 4'd1;
          end
        end else if (is_term) begin
          state_d = ST_IDLE;
          if (cnt_q == 4'd0) begin
            err_d = 1'b1;
          end else begin
            upd_d  = 1'b1;
            ufld_d = field_q;
            case (field_q)
              FLD_WAVE:  wave_d  = acc_q[WAVE_W-1:0];
              FLD_FREQ:  freq_d  = acc_q[FREQ_W-1:0];
              FLD_AMP:   amp_d   = acc_q[AMP_W-1:0];
              default:   phase_d = acc_q[PHASE_W-1:0];
            endcase
          end
        end else if (is_letter) begin
          // A new letter restarts collection rather than dropping to IDLE.
          err_d   = 1'b1;
          field_d = letter_fld;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
`ifdef AWG_CMD_TIMEOUT_EN
    else if (state_q == ST_COLLECT) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      field_q <= FLD_WAVE;
      acc_q   <= '0;
      cnt_q   <= '0;
      wave_q  <= WAVE_W'(DEF_WAVE);
      freq_q  <= FREQ_W'(DEF_FREQ);
      amp_q   <= AMP_W'(DEF_AMP);
      phase_q <= PHASE_W'(DEF_PHASE);
      upd_q   <= 1'b0;
      ufld_q  <= 2'd0;
      err_q   <= 1'b0;
`ifdef AWG_CMD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      phase_q <= phase_d;
      upd_q   <= upd_d;
      ufld_q  <= ufld_d;
      err_q   <= err_d;
`ifdef AWG_CMD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign wave_sel  = wave_q;
  assign freq_word = freq_q;
  assign amp_sel   = amp_q;
  assign phase_off = phase_q;
  assign upd       = upd_q;
  assign upd_field = ufld_q;
  assign cmd_err   = err_q;
  assign busy      = (state_q == ST_COLLECT);

endmodule
